// File: rtl/bcd_seq_ctl_pkg.sv
// Shared types and display-code helpers for the BCD adder sequencing controller.
package bcd_ctl_pkg;

    typedef enum logic [1:0] {ENTER, CIN, CALC, SHOW} state_t;

    function automatic int cin_code(input int num_ops);
        return num_ops;
    endfunction

    function automatic int rslt_code(input int num_ops);
        return num_ops + 1;
    endfunction

    function automatic int err_code(input int sel_w);
        return (2 ** sel_w) - 2;
    endfunction

    // Operand codes, CIN, RSLT and ERR must all fit in SEL_W bits without overlap.
    function automatic bit params_legal(input int num_ops, input int sel_w);
        return (num_ops >= 2) && (num_ops <= (2 ** sel_w) - 4);
    endfunction

endpackage

// File: rtl/bcd_seq_ctl_if.sv
// Button/strobe bundle between the push-button front end and the operand/result registers.
interface bcd_seq_ctl_if #(
    parameter int NUM_OPS = 2,
    parameter int SEL_W   = 3
);
    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    logic               next_btn;
    logic               back_btn;
    logic               out_of_range;
    logic               accum_mode;
    logic [NUM_OPS-1:0] load_op;
    logic               acc_sel;
    logic               load_cin;
    logic               load_rslt;
    logic [SEL_W-1:0]   out_mux_sel;
    logic               err;
    logic [IDX_W-1:0]   op_idx;

    modport master (
        output next_btn, back_btn, out_of_range, accum_mode,
        input  load_op, acc_sel, load_cin, load_rslt, out_mux_sel, err, op_idx
    );

    modport slave (
        input  next_btn, back_btn, out_of_range, accum_mode,
        output load_op, acc_sel, load_cin, load_rslt, out_mux_sel, err, op_idx
    );

endinterface

// File: rtl/bcd_seq_ctl_btn_edge.sv
// Rising-edge detector for a pre-synchronised button level.
module btn_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);
    logic btn_q;

    // Resetting to 1 means a button already held at reset release is not a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) btn_q <= 1'b1;
        else          btn_q <= btn;
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/bcd_seq_ctl.sv
// Operand/carry/result load sequencer for the multi-operand BCD adder.
//  state | meaning
//  ENTER | operand op_idx being keyed in; next loads it, back steps one operand back
//  CIN   | carry-in being keyed in; next loads it, back returns to the last operand
//  CALC  | single cycle; result register load issued, buttons ignored
//  SHOW  | result displayed; next restarts, optionally chaining result into operand 0
module bcd_seq_ctl
    import bcd_ctl_pkg::*;
#(
    parameter int NUM_OPS = 2,
    parameter int HAS_CIN = 1,
    parameter int SEL_W   = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    bcd_seq_ctl_if.slave  bus
);
    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [SEL_W-1:0] CIN_CODE  = SEL_W'(cin_code(NUM_OPS));
    localparam logic [SEL_W-1:0] RSLT_CODE = SEL_W'(rslt_code(NUM_OPS));
    localparam logic [SEL_W-1:0] ERR_CODE  = SEL_W'(err_code(SEL_W));
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OPS - 1);

    if (!params_legal(NUM_OPS, SEL_W)) begin : g_bad_params
        $error("bcd_seq_ctl: NUM_OPS does not fit the SEL_W display code space");
    end

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [NUM_OPS-1:0] load_op;
    logic               acc_sel;
    logic               load_cin;
    logic               load_rslt;
    logic [SEL_W-1:0]   sel;
    logic               err;
    logic               next_p;
    logic               back_p;

    btn_edge u_next_edge (.clk(clk), .reset_n(reset_n), .btn(bus.next_btn), .press(next_p));
    btn_edge u_back_edge (.clk(clk), .reset_n(reset_n), .btn(bus.back_btn), .press(back_p));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ENTER;
            idx       <= '0;
            load_op   <= '0;
            acc_sel   <= 1'b0;
            load_cin  <= 1'b0;
            load_rslt <= 1'b0;
            sel       <= '0;
            err       <= 1'b0;
        end else begin
            load_op   <= '0;
            acc_sel   <= 1'b0;
            load_cin  <= 1'b0;
            load_rslt <= 1'b0;
            case (state)
                ENTER: begin
                    if (next_p) begin
                        if (bus.out_of_range) begin
                            err <= 1'b1;
                            sel <= ERR_CODE;
                        end else begin
                            load_op <= NUM_OPS'(1) << idx;
                            err     <= 1'b0;
                            if (idx < LAST_IDX) begin
                                idx <= idx + IDX_W'(1);
                                sel <= SEL_W'(idx) + SEL_W'(1);
                            end else if (HAS_CIN != 0) begin
                                state <= CIN;
                                sel   <= CIN_CODE;
                            end else begin
                                state <= CALC;
                                sel   <= RSLT_CODE;
                            end
                        end
                    end else if (back_p) begin
                        err <= 1'b0;
                        if (idx != '0) begin
                            idx <= idx - IDX_W'(1);
                            sel <= SEL_W'(idx) - SEL_W'(1);
                        end else begin
                            sel <= '0;
                        end
                    end
                end
                CIN: begin
                    if (next_p) begin
                        load_cin <= 1'b1;
                        state    <= CALC;
                        sel      <= RSLT_CODE;
                    end else if (back_p) begin
                        state <= ENTER;
                        idx   <= LAST_IDX;
                        sel   <= SEL_W'(LAST_IDX);
                    end
                end
                CALC: begin
                    load_rslt <= 1'b1;
                    state     <= SHOW;
                    sel       <= RSLT_CODE;
                end
                SHOW: begin
                    if (next_p) begin
                        state <= ENTER;
                        if (bus.accum_mode) begin
                            load_op <= NUM_OPS'(1);
                            acc_sel <= 1'b1;
                            idx     <= IDX_W'(1);
                            sel     <= SEL_W'(1);
                        end else begin
                            idx <= '0;
                            sel <= '0;
                        end
                    end
                end
                default: state <= ENTER;
            endcase
        end
    end

    assign bus.load_op     = load_op;
    assign bus.acc_sel     = acc_sel;
    assign bus.load_cin    = load_cin;
    assign bus.load_rslt   = load_rslt;
    assign bus.out_mux_sel = sel;
    assign bus.err         = err;
    assign bus.op_idx      = idx;

endmodule

// File: tb/tb_bcd_seq_ctl.sv
// Directed bench: DUT A (2 operands, carry-in) and DUT B (4 operands, no carry-in).
module tb_bcd_seq_ctl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bcd_seq_ctl_if #(.NUM_OPS(2), .SEL_W(3)) ia ();
    bcd_seq_ctl_if #(.NUM_OPS(4), .SEL_W(3)) ib ();

    bcd_seq_ctl #(.NUM_OPS(2), .HAS_CIN(1), .SEL_W(3)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
    bcd_seq_ctl #(.NUM_OPS(4), .HAS_CIN(0), .SEL_W(3)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));

    typedef struct {
        logic       n, b, r, a;
        logic [1:0] lop;
        logic       acc, cin, rs;
        logic [2:0] sel;
        logic       err;
        logic       idx;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t v(input logic n, b, r, a, input logic [1:0] lop,
                               input logic acc, cin, rs, input logic [2:0] sel,
                               input logic err, idx);
        vec_t t;
        t.n = n; t.b = b; t.r = r; t.a = a;
        t.lop = lop; t.acc = acc; t.cin = cin; t.rs = rs;
        t.sel = sel; t.err = err; t.idx = idx;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string p, input logic [1:0] lop, input logic acc, cin, rs,
                         input logic [2:0] sel, input logic err, idx);
        chk({p, ".load_op"},   32'(ia.load_op),     32'(lop));
        chk({p, ".acc_sel"},   32'(ia.acc_sel),     32'(acc));
        chk({p, ".load_cin"},  32'(ia.load_cin),    32'(cin));
        chk({p, ".load_rslt"}, 32'(ia.load_rslt),   32'(rs));
        chk({p, ".sel"},       32'(ia.out_mux_sel), 32'(sel));
        chk({p, ".err"},       32'(ia.err),         32'(err));
        chk({p, ".op_idx"},    32'(ia.op_idx),      32'(idx));
    endtask

    task automatic chk_b(input string p, input logic [3:0] lop, input logic rs,
                         input logic [2:0] sel, input logic [1:0] idx);
        chk({p, ".load_op"},   32'(ib.load_op),     32'(lop));
        chk({p, ".load_cin"},  32'(ib.load_cin),    32'(0));
        chk({p, ".load_rslt"}, 32'(ib.load_rslt),   32'(rs));
        chk({p, ".sel"},       32'(ib.out_mux_sel), 32'(sel));
        chk({p, ".op_idx"},    32'(ib.op_idx),      32'(idx));
    endtask

    initial begin
        ia.next_btn = 1'b1; ia.back_btn = 1'b0; ia.out_of_range = 1'b0; ia.accum_mode = 1'b0;
        ib.next_btn = 1'b0; ib.back_btn = 1'b0; ib.out_of_range = 1'b0; ib.accum_mode = 1'b0;

        // n b r a | lop acc cin rs | sel err idx
        tbl.push_back(v(1,0,0,0, 1,0,0,0, 1,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 1,0,1));
        tbl.push_back(v(1,0,0,0, 2,0,0,0, 2,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 2,0,1));
        tbl.push_back(v(1,0,0,0, 0,0,1,0, 3,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,1, 3,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 3,0,1));
        tbl.push_back(v(1,0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(1,0,1,0, 0,0,0,0, 6,1,0));
        tbl.push_back(v(0,0,1,0, 0,0,0,0, 6,1,0));
        tbl.push_back(v(1,0,0,0, 1,0,0,0, 1,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 1,0,1));
        tbl.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(1,0,1,0, 0,0,0,0, 6,1,0));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 6,1,0));
        tbl.push_back(v(0,1,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(1,0,0,0, 1,0,0,0, 1,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 1,0,1));
        tbl.push_back(v(1,0,0,0, 2,0,0,0, 2,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 2,0,1));
        tbl.push_back(v(0,1,0,0, 0,0,0,0, 1,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 1,0,1));
        tbl.push_back(v(1,0,0,0, 2,0,0,0, 2,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 2,0,1));
        tbl.push_back(v(1,0,1,0, 0,0,1,0, 3,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,1, 3,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 3,0,1));
        tbl.push_back(v(1,0,0,1, 1,1,0,0, 1,0,1));
        tbl.push_back(v(0,0,0,1, 0,0,0,0, 1,0,1));
        tbl.push_back(v(1,0,0,0, 2,0,0,0, 2,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 2,0,1));
        tbl.push_back(v(1,0,0,0, 0,0,1,0, 3,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,1, 3,0,1));
        tbl.push_back(v(0,1,0,0, 0,0,0,0, 3,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 3,0,1));
        tbl.push_back(v(1,0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(v(1,1,0,0, 1,0,0,0, 1,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 1,0,1));
        tbl.push_back(v(1,0,0,0, 2,0,0,0, 2,0,1));
        tbl.push_back(v(1,0,0,0, 0,0,0,0, 2,0,1));
        tbl.push_back(v(1,0,0,0, 0,0,0,0, 2,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0,0, 2,0,1));

        // Reset values, with next held through reset release.
        #12;
        chk_a("rst_a", 0, 0, 0, 0, 0, 0, 0);
        chk_b("rst_b", 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();
        chk_a("held0", 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_a("held1", 0, 0, 0, 0, 0, 0, 0);
        ia.next_btn = 1'b0;
        tick();

        foreach (tbl[i]) begin
            ia.next_btn     = tbl[i].n;
            ia.back_btn     = tbl[i].b;
            ia.out_of_range = tbl[i].r;
            ia.accum_mode   = tbl[i].a;
            tick();
            chk_a($sformatf("row%0d", i), tbl[i].lop, tbl[i].acc, tbl[i].cin, tbl[i].rs,
                  tbl[i].sel, tbl[i].err, tbl[i].idx);
        end

        // Reset while load_rslt is high: pulse must drop without a clock edge.
        ia.next_btn = 1'b1;
        tick();
        chk_a("to_calc", 0, 0, 1, 0, 3, 0, 1);
        ia.next_btn = 1'b0;
        tick();
        chk_a("rslt_pulse", 0, 0, 0, 1, 3, 0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_a("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();
        chk_a("post_rst", 0, 0, 0, 0, 0, 0, 0);
        ia.next_btn = 1'b1;
        tick();
        chk_a("post_rst_load", 1, 0, 0, 0, 1, 0, 1);
        ia.next_btn = 1'b0;
        tick();

        // Four operands, no carry-in step.
        chk_b("b_idle", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            ib.next_btn = 1'b1;
            tick();
            chk_b($sformatf("b_press%0d", i), 4'(1 << i), 0,
                  (i == 3) ? 3'd5 : 3'(i + 1), (i == 3) ? 2'd3 : 2'(i + 1));
            ib.next_btn = 1'b0;
            tick();
            chk_b($sformatf("b_rel%0d", i), 0, (i == 3) ? 1'b1 : 1'b0,
                  (i == 3) ? 3'd5 : 3'(i + 1), (i == 3) ? 2'd3 : 2'(i + 1));
        end
        tick();
        chk_b("b_show", 0, 0, 5, 3);
        ib.next_btn = 1'b1;
        tick();
        chk_b("b_restart", 0, 0, 0, 0);
        ib.next_btn = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
